// File: rtl/riscv_hzd_pkg.sv
// Shared types and opcode constants for the pipeline hazard/forwarding unit.
//   fwd_sel_e   : forwarding select encoding driven onto forward_a/forward_b
//   hzd_entry_t : one shadow pipeline slot {vld, rd, wren, load}
//   uses_rs1/2  : source-register usage decoded from the major opcode
package riscv_hzd_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_WB  = 2'd1,
      FWD_MEM = 2'd2,
      FWD_EX  = 2'd3
   } fwd_sel_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef struct packed {
      logic       vld;
      logic [4:0] rd;
      logic       wren;
      logic       load;
   } hzd_entry_t;

   function automatic logic uses_rs1(input logic [6:0] op);
      case (op)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: return 1'b1;
         OP_JAL, OP_LUI, OP_AUIPC:                         return 1'b0;
         default:                                          return 1'b0;
      endcase
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      case (op)
         OP_R, OP_STORE, OP_BRANCH: return 1'b1;
         default:                   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/hzd_fwd_sel.sv
// Compares one ID-stage source register against the EX/MEM/WB shadow entries.
//   i_rs       : source register index from the ID instruction
//   i_used     : the ID instruction actually reads this source
//   i_ex/mem/wb: shadow pipeline entries
//   o_sel      : forwarding select (EX non-load > MEM non-load > WB > regfile)
//   o_load_hit : source matches a load still in EX or MEM (load-use hazard)
module hzd_fwd_sel
   import riscv_hzd_pkg::*;
(
   input  logic [4:0] i_rs,
   input  logic       i_used,
   input  hzd_entry_t i_ex,
   input  hzd_entry_t i_mem,
   input  hzd_entry_t i_wb,
   output fwd_sel_e   o_sel,
   output logic       o_load_hit
);

   logic w_hit_ex;
   logic w_hit_mem;
   logic w_hit_wb;
   logic w_unused_wb_load;

   function automatic logic entry_match(input hzd_entry_t e, input logic [4:0] rs);
      return e.vld && e.wren && (e.rd != 5'd0) && (e.rd == rs);
   endfunction

   assign w_hit_ex  = i_used && entry_match(i_ex, i_rs);
   assign w_hit_mem = i_used && entry_match(i_mem, i_rs);
   assign w_hit_wb  = i_used && entry_match(i_wb, i_rs);

   // Load data is already on the write-back bus, so a WB load forwards normally.
   assign w_unused_wb_load = i_wb.load;

   always_comb begin
      o_sel = FWD_RF;
      if (w_hit_ex && !i_ex.load)
         o_sel = FWD_EX;
      else if (w_hit_mem && !i_mem.load)
         o_sel = FWD_MEM;
      else if (w_hit_wb)
         o_sel = FWD_WB;
   end

   assign o_load_hit = (w_hit_ex && i_ex.load) || (w_hit_mem && i_mem.load);

endmodule

// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard controller for the 5-stage core.
// Tracks its own EX/MEM/WB shadow of {vld, rd, wren, load} and derives, purely
// combinationally from that shadow and the ID inputs:
//   forward_a/forward_b : rs1/rs2 source select (0 rf, 1 wb, 2 mem, 3 ex)
//   stall_pc/stall_ifid : hold fetch (load-use stall or memory freeze)
//   flush_ifid          : taken branch in EX, squash IF/ID
//   flush_idex          : bubble into ID/EX (load-use stall or taken branch)
//   stall_cnt/flush_cnt : saturating event counters
// Inputs: i_clk, i_reset (sync, active-high), instr_id, id_vld, rd_wren_id,
// is_load_id, br_taken_ex, mem_stall.
module hazard_fwd_unit
   import riscv_hzd_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [31:0]      instr_id,
   input  logic             id_vld,
   input  logic             rd_wren_id,
   input  logic             is_load_id,
   input  logic             br_taken_ex,
   input  logic             mem_stall,
   output logic [1:0]       forward_a,
   output logic [1:0]       forward_b,
   output logic             stall_pc,
   output logic             stall_ifid,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   hzd_entry_t       r_ex;
   hzd_entry_t       r_mem;
   hzd_entry_t       r_wb;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic [6:0]       w_op;
   logic             w_use_rs1;
   logic             w_use_rs2;
   fwd_sel_e         w_sel_rs1;
   fwd_sel_e         w_sel_rs2;
   logic             w_lh_rs1;
   logic             w_lh_rs2;
   logic             w_load_use;
   hzd_entry_t       w_ex_nxt;
   logic             w_unused_fields;

   assign w_op      = instr_id[6:0];
   assign w_use_rs1 = uses_rs1(w_op);
   assign w_use_rs2 = uses_rs2(w_op);

   // funct3/funct7 do not influence hazards.
   assign w_unused_fields = ^{instr_id[31:25], instr_id[14:12]};

   hzd_fwd_sel u_sel_rs1 (
      .i_rs       (instr_id[19:15]),
      .i_used     (w_use_rs1),
      .i_ex       (r_ex),
      .i_mem      (r_mem),
      .i_wb       (r_wb),
      .o_sel      (w_sel_rs1),
      .o_load_hit (w_lh_rs1)
   );

   hzd_fwd_sel u_sel_rs2 (
      .i_rs       (instr_id[24:20]),
      .i_used     (w_use_rs2),
      .i_ex       (r_ex),
      .i_mem      (r_mem),
      .i_wb       (r_wb),
      .o_sel      (w_sel_rs2),
      .o_load_hit (w_lh_rs2)
   );

   assign forward_a  = w_sel_rs1;
   assign forward_b  = w_sel_rs2;
   assign w_load_use = id_vld && (w_lh_rs1 || w_lh_rs2);

   // Freeze beats branch flush beats load-use stall. A frozen branch stays in
   // EX and is acted on once mem_stall drops.
   always_comb begin
      stall_pc   = 1'b0;
      stall_ifid = 1'b0;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      if (mem_stall) begin
         stall_pc   = 1'b1;
         stall_ifid = 1'b1;
      end else if (br_taken_ex) begin
         flush_ifid = 1'b1;
         flush_idex = 1'b1;
      end else if (w_load_use) begin
         stall_pc   = 1'b1;
         stall_ifid = 1'b1;
         flush_idex = 1'b1;
      end
   end

   always_comb begin
      w_ex_nxt = '0;
      if (!flush_idex) begin
         w_ex_nxt.vld  = id_vld;
         w_ex_nxt.rd   = instr_id[11:7];
         w_ex_nxt.wren = rd_wren_id;
         w_ex_nxt.load = is_load_id;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ex        <= '0;
         r_mem       <= '0;
         r_wb        <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (!mem_stall) begin
         r_wb  <= r_mem;
         r_mem <= r_ex;
         r_ex  <= w_ex_nxt;
         if (br_taken_ex) begin
            if (r_flush_cnt != '1)
               r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end else if (w_load_use) begin
            if (r_stall_cnt != '1)
               r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

   localparam int CNT_W = 5;
   localparam int MAXC  = (1 << CNT_W) - 1;

   localparam int K_ADD = 0, K_ADDI = 1, K_LW = 2, K_SW = 3, K_BEQ = 4,
                  K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8;

   logic             i_clk = 1'b0;
   logic             i_reset;
   logic [31:0]      instr_id;
   logic             id_vld, rd_wren_id, is_load_id, br_taken_ex, mem_stall;
   logic [1:0]       forward_a, forward_b;
   logic             stall_pc, stall_ifid, flush_ifid, flush_idex;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   hazard_fwd_unit #(.CNT_W(CNT_W)) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .instr_id    (instr_id),
      .id_vld      (id_vld),
      .rd_wren_id  (rd_wren_id),
      .is_load_id  (is_load_id),
      .br_taken_ex (br_taken_ex),
      .mem_stall   (mem_stall),
      .forward_a   (forward_a),
      .forward_b   (forward_b),
      .stall_pc    (stall_pc),
      .stall_ifid  (stall_ifid),
      .flush_ifid  (flush_ifid),
      .flush_idex  (flush_idex),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   always #5 i_clk = ~i_clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: history of what entered EX, newest first.
   // Distance 0 = EX, 1 = MEM, 2 = WB.
   typedef struct {
      bit       vld;
      bit [4:0] rd;
      bit       wr;
      bit       ld;
   } rec_t;

   rec_t hist[$];
   int   m_scnt, m_fcnt;
   bit   m_use1, m_use2;
   bit   e_hz;

   logic [1:0]       s_fa, s_fb;
   logic             s_spc, s_sif, s_fif, s_fid;
   logic [CNT_W-1:0] s_scnt, s_fcnt;

   function automatic rec_t bubble();
      rec_t r;
      r.vld = 0; r.rd = 0; r.wr = 0; r.ld = 0;
      return r;
   endfunction

   function automatic bit writes(input int d, input bit [4:0] rs);
      return hist[d].vld && hist[d].wr && hist[d].rd == rs && rs != 0;
   endfunction

   function automatic int exp_sel(input bit use_rs, input bit [4:0] rs);
      if (!use_rs) return 0;
      for (int d = 0; d < 3; d++) begin
         if (writes(d, rs)) begin
            if (d == 2) return 1;
            if (!hist[d].ld) return 3 - d;
         end
      end
      return 0;
   endfunction

   function automatic bit load_hit(input bit use_rs, input bit [4:0] rs);
      if (!use_rs) return 0;
      for (int d = 0; d < 2; d++)
         if (writes(d, rs) && hist[d].ld) return 1;
      return 0;
   endfunction

   function automatic int sat(input int v);
      return (v >= MAXC) ? MAXC : v + 1;
   endfunction

   task automatic model_reset();
      hist = {};
      repeat (3) hist.push_back(bubble());
      m_scnt = 0;
      m_fcnt = 0;
   endtask

   task automatic set_instr(input int k, input bit [4:0] rd, input bit [4:0] rs1,
                            input bit [4:0] rs2, input bit vld);
      logic [6:0] op;
      case (k)
         K_ADD:   op = 7'b0110011;
         K_ADDI:  op = 7'b0010011;
         K_LW:    op = 7'b0000011;
         K_SW:    op = 7'b0100011;
         K_BEQ:   op = 7'b1100011;
         K_JAL:   op = 7'b1101111;
         K_JALR:  op = 7'b1100111;
         K_LUI:   op = 7'b0110111;
         default: op = 7'b0010111;
      endcase
      instr_id   = {7'($urandom), rs2, rs1, 3'($urandom), rd, op};
      id_vld     = vld;
      rd_wren_id = !(k == K_SW || k == K_BEQ);
      is_load_id = (k == K_LW);
      m_use1     = (k == K_ADD || k == K_ADDI || k == K_LW || k == K_SW ||
                    k == K_BEQ || k == K_JALR);
      m_use2     = (k == K_ADD || k == K_SW || k == K_BEQ);
   endtask

   task automatic nop();
      set_instr(K_ADDI, 0, 0, 0, 1);
   endtask

   // One cycle: check all outputs mid-cycle, then clock DUT and model.
   task automatic tick();
      int ea, eb;
      bit xs_pc, xs_if, xf_if, xf_id;
      rec_t r;
      @(negedge i_clk);
      ea   = exp_sel(m_use1, instr_id[19:15]);
      eb   = exp_sel(m_use2, instr_id[24:20]);
      e_hz = id_vld && (load_hit(m_use1, instr_id[19:15]) || load_hit(m_use2, instr_id[24:20]));
      xs_pc = 0; xs_if = 0; xf_if = 0; xf_id = 0;
      if (mem_stall) begin
         xs_pc = 1; xs_if = 1;
      end else if (br_taken_ex) begin
         xf_if = 1; xf_id = 1;
      end else if (e_hz) begin
         xs_pc = 1; xs_if = 1; xf_id = 1;
      end
      chk("forward_a",  32'(forward_a),  32'(ea));
      chk("forward_b",  32'(forward_b),  32'(eb));
      chk("stall_pc",   32'(stall_pc),   32'(xs_pc));
      chk("stall_ifid", 32'(stall_ifid), 32'(xs_if));
      chk("flush_ifid", 32'(flush_ifid), 32'(xf_if));
      chk("flush_idex", 32'(flush_idex), 32'(xf_id));
      chk("stall_cnt",  32'(stall_cnt),  32'(m_scnt));
      chk("flush_cnt",  32'(flush_cnt),  32'(m_fcnt));
      s_fa = forward_a; s_fb = forward_b; s_spc = stall_pc; s_sif = stall_ifid;
      s_fif = flush_ifid; s_fid = flush_idex; s_scnt = stall_cnt; s_fcnt = flush_cnt;
      @(posedge i_clk);
      if (i_reset) begin
         model_reset();
      end else if (!mem_stall) begin
         if (br_taken_ex || e_hz) begin
            r = bubble();
         end else begin
            r.vld = id_vld; r.rd = instr_id[11:7]; r.wr = rd_wren_id; r.ld = is_load_id;
         end
         hist.push_front(r);
         void'(hist.pop_back());
         if (br_taken_ex) m_fcnt = sat(m_fcnt);
         else if (e_hz)   m_scnt = sat(m_scnt);
      end
      #1;
   endtask

   int prev_s, prev_f;

   initial begin
      i_reset = 1; br_taken_ex = 0; mem_stall = 0;
      nop();
      repeat (2) @(posedge i_clk);
      #1;
      model_reset();
      tick();
      chk("rst_fa", 32'(s_fa), 0);
      chk("rst_stall_pc", 32'(s_spc), 0);
      chk("rst_flush_idex", 32'(s_fid), 0);
      i_reset = 0;

      // back-to-back dependency: EX forward
      set_instr(K_ADD, 5, 1, 2, 1); tick();
      set_instr(K_ADD, 6, 5, 3, 1); tick();
      chk("p1_fa", 32'(s_fa), 3);
      chk("p1_fb", 32'(s_fb), 0);
      chk("p1_stall", 32'(s_spc), 0);

      // distance 2/3/4: MEM, WB, regfile
      for (int n = 1; n <= 3; n++) begin
         set_instr(K_ADD, 5, 1, 2, 1); tick();
         repeat (n) begin nop(); tick(); end
         set_instr(K_ADD, 7, 4, 5, 1); tick();
         chk("p2_fb", 32'(s_fb), 32'(3 - n));
      end

      // load-use: two stall cycles then WB forward
      set_instr(K_LW, 8, 1, 0, 1); tick();
      set_instr(K_ADD, 9, 8, 8, 1); tick();
      prev_s = int'(s_scnt);
      chk("p3_stall1", 32'({s_spc, s_sif, s_fid}), 3'b111);
      tick();
      chk("p3_stall2", 32'({s_spc, s_sif, s_fid}), 3'b111);
      tick();
      chk("p3_fa", 32'(s_fa), 1);
      chk("p3_fb", 32'(s_fb), 1);
      chk("p3_nostall", 32'(s_spc), 0);
      chk("p3_scnt", 32'(int'(s_scnt) - prev_s), 2);

      // branch flush overrides load-use
      set_instr(K_LW, 8, 1, 0, 1); tick();
      set_instr(K_ADD, 9, 8, 8, 1); br_taken_ex = 1; tick();
      prev_s = int'(s_scnt); prev_f = int'(s_fcnt);
      chk("p4_flush", 32'({s_fif, s_fid, s_spc}), 3'b110);
      br_taken_ex = 0; nop(); tick();
      chk("p4_scnt", 32'(s_scnt), 32'(prev_s));
      chk("p4_fcnt", 32'(s_fcnt), 32'(prev_f + 1));

      // x0 never forwards; unused source never stalls
      set_instr(K_ADDI, 0, 0, 1, 1); tick();
      set_instr(K_ADD, 3, 0, 0, 1); tick();
      chk("p5_fa", 32'(s_fa), 0);
      chk("p5_fb", 32'(s_fb), 0);
      set_instr(K_LW, 10, 1, 0, 1); tick();
      set_instr(K_LUI, 10, 10, 10, 1); tick();
      chk("p5_lui_stall", 32'(s_spc), 0);

      // freeze during load-use, then finish remaining stall cycles
      set_instr(K_LW, 8, 1, 0, 1); tick();
      set_instr(K_ADD, 9, 8, 8, 1); mem_stall = 1;
      repeat (3) begin
         tick();
         chk("p6_frz", 32'({s_spc, s_sif, s_fid, s_fif}), 4'b1100);
      end
      mem_stall = 0; tick();
      chk("p6_st1", 32'(s_fid), 1);
      tick();
      chk("p6_st2", 32'(s_fid), 1);
      tick();
      chk("p6_done", 32'({s_spc, s_fa}), 3'b001);

      // reset mid-stall
      set_instr(K_LW, 8, 1, 0, 1); tick();
      set_instr(K_ADD, 9, 8, 8, 1); tick();
      i_reset = 1; tick();
      i_reset = 0; tick();
      chk("p7_out", 32'({s_fa, s_fb, s_spc, s_sif, s_fif, s_fid}), 0);
      chk("p7_cnt", 32'({s_scnt, s_fcnt}), 0);

      // counter saturation
      br_taken_ex = 1;
      repeat (MAXC + 8) tick();
      chk("sat_fcnt", 32'(s_fcnt), 32'(MAXC));
      br_taken_ex = 0;
      repeat (MAXC / 2 + 6) begin
         set_instr(K_LW, 1, 2, 0, 1); tick();
         set_instr(K_ADD, 2, 1, 1, 1); tick(); tick(); tick();
      end
      chk("sat_scnt", 32'(s_scnt), 32'(MAXC));

      // randomized traffic
      i_reset = 1; tick(); i_reset = 0;
      for (int c = 0; c < 800; c++) begin
         set_instr($urandom_range(0, 8), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   $urandom_range(0, 9) != 0);
         br_taken_ex = ($urandom_range(0, 9) == 0);
         mem_stall   = ($urandom_range(0, 6) == 0);
         i_reset     = ($urandom_range(0, 299) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core. It produces the ID-stage forwarding selects (forward_a/forward_b), the load-use stalls, the taken-branch flushes and the global freeze used by the ID stage and the pipeline registers.
- Keeps its own shadow pipeline (EX/MEM/WB) of destination register, write-enable and load flag, so it needs no taps from downstream stages beyond branch-taken and the memory stall.

Parameters:
- CNT_W, 32, width of the stall and flush performance counters (saturating).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- instr_id  in  32  instruction currently in ID
- id_vld  in  1  ID holds a valid instruction (inst_vld from the control unit)
- rd_wren_id  in  1  ID instruction writes rd
- is_load_id  in  1  ID instruction is a load (write-back source is the LSU)
- br_taken_ex  in  1  branch/jump in EX resolved taken (pc_sel)
- mem_stall  in  1  APB LSU busy; freezes the whole pipeline
- forward_a  out  2  rs1 source: 0 regfile, 1 wb_data, 2 alu_data_mem, 3 alu_data
- forward_b  out  2  rs2 source, same encoding
- stall_pc  out  1  hold PC
- stall_ifid  out  1  hold IF/ID register
- flush_ifid  out  1  clear IF/ID to NOP
- flush_idex  out  1  insert bubble into ID/EX
- stall_cnt  out  CNT_W  load-use stall cycles
- flush_cnt  out  CNT_W  branch flush events

Behaviour:
- Shadow entries EX, MEM and WB each hold {vld, rd[4:0], wren, load}. Reset clears every vld, clears both counters and sets all entries to 0.
- Every output is combinational from the shadow entries and the ID inputs. With all shadow entries invalid after reset, the outputs are 0.
- rs usage is decoded from instr_id[6:0]:
  - rs1 used by R, I-ALU, load, store, branch and JALR.
  - rs2 used by R, store and branch.
  - LUI, AUIPC and JAL use neither.
  - An unused source forces its forward select to 0 and never causes a stall.
- An entry matches a source when vld & wren & rd != 0 & rd == rs.
- Forward priority per source:
  - EX match and not load -> 3.
  - Else MEM match and not load -> 2.
  - Else WB match -> 1. A load in WB is legal here.
  - Else 0.
- Load-use hazard: id_vld and a used source matches an EX or MEM entry with load=1. The result is a 2-cycle stall for a load in EX and a 1-cycle stall for a load in MEM.
  - While the hazard is active: stall_pc=1, stall_ifid=1, flush_idex=1.
  - The forward selects remain computed but are don't-care.
- Branch: br_taken_ex=1 gives flush_ifid=1 and flush_idex=1, and stall_pc=0.
  - Flush overrides a load-use stall in the same cycle.
  - flush_cnt increments by 1.
- Freeze: mem_stall=1 gives stall_pc=1, stall_ifid=1, flush_idex=0, flush_ifid=0.
  - The shadow entries hold and the counters do not count.
  - Freeze overrides both branch flush and load-use. The branch stays in EX and is acted on when mem_stall drops.
- Shadow advance, when not frozen:
  - WB <= MEM, MEM <= EX.
  - EX <= bubble (vld=0) if flush_idex; otherwise EX <= {id_vld, instr_id[11:7], rd_wren_id, is_load_id}.
- stall_cnt increments on each load-use stall cycle that is neither frozen nor flushed.
- Both counters saturate at all-ones; they do not wrap.
- Reset asserted mid-stall or mid-flush clears all state on the next edge, and the outputs return to 0.
- A WB entry with rd == rs takes effect as forward 1 in the same cycle as the regfile write. This covers the regfile not having write-through.

Decomposition:
- Package riscv_hzd_pkg:
  - enum fwd_sel_e {FWD_RF=0, FWD_WB=1, FWD_MEM=2, FWD_EX=3}.
  - Opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
  - Packed struct hzd_entry_t {vld, rd, wren, load}.
- One sub-module, hzd_fwd_sel: combinational rs-versus-entries comparator that returns fwd_sel_e and a load-hit flag. It is instantiated twice, once for rs1 and once for rs2.

Test Plan:
- add x5,x1,x2 then add x6,x5,x3 back-to-back -> second in ID: forward_a=3, forward_b=0, no stall.
- add x5 ; nop ; sub x7,x4,x5 -> forward_b=2. With two nops between -> forward_b=1. With three nops -> 0.
- lw x8,0(x1) then add x9,x8,x8 -> 2 cycles of stall_pc=stall_ifid=flush_idex=1, then forward_a=forward_b=1. stall_cnt=2.
- Load-use stall in cycle N with br_taken_ex=1 in the same cycle -> flush_ifid=flush_idex=1, stall_pc=0. flush_cnt+1, stall_cnt unchanged.
- addi x0,x0,1 then add x3,x0,x0 -> forward selects 0. lui x10 after lw x10 -> no stall.
- mem_stall held 3 cycles during a load-use hazard -> stall_pc=1, flush_idex=0, shadow frozen. After release the remaining stall cycles complete. A reset pulse mid-sequence -> all outputs 0 and counters 0 on the next cycle.
